// File: rtl/cache_cmd_pkg.sv
// Shared types for the cache command sequencer: command codes, FSM states
// and the legal-command filter.
package cache_cmd_pkg;

    typedef enum logic [3:0] {
        READ_REQ_L1_D     = 4'd0,
        WRITE_REQ_L1_D    = 4'd1,
        READ_REQ_L1_I     = 4'd2,
        SNOOP_INVALIDATE  = 4'd3,
        SNOOP_READ        = 4'd4,
        SNOOP_WRITE       = 4'd5,
        SNOOP_READ_WITH_M = 4'd6,
        CLR_CACHE_RST     = 4'd8,
        PRINT_CONTENTS    = 4'd9
    } n_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } seq_state_t;

    function automatic logic is_legal_cmd(input logic [3:0] code);
        return (code <= 4'd6) || (code == CLR_CACHE_RST) || (code == PRINT_CONTENTS);
    endfunction

endpackage

// File: rtl/cache_cmd_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate count register.
module cache_cmd_fifo
    import cache_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 36
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/cache_cmd_sequencer.sv
// Buffers trace commands and issues them to the cache one at a time with a
// watchdog on the cache handshake. Define CACHE_CMD_SEQ_STATS_EN for issue counters.
module cache_cmd_sequencer
    import cache_cmd_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_n,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_ready,
    input  logic              opr_finished,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        n,
    output logic              valid,
    output logic              busy,
    output logic              err_bad_cmd,
    output logic              err_timeout,
    output logic [31:0]       stat_rd,
    output logic [31:0]       stat_wr,
    output logic [31:0]       stat_snoop
);

    localparam int unsigned         WD_W    = $clog2(TIMEOUT);
    // Abort on the edge at which the counter would reach TIMEOUT-1.
    localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT - 2);

    seq_state_t          r_state;
    logic [ADDR_W-1:0]   r_address;
    logic [3:0]          r_n;
    logic                r_valid;
    logic                r_err_bad_cmd;
    logic                r_err_timeout;
    logic [WD_W-1:0]     r_wdog;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W+3:0]   w_head;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_push   = w_accept && is_legal_cmd(cmd_n);
    assign w_pop    = (r_state == IDLE) && !w_empty;

    cache_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 4)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({cmd_addr, cmd_n}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= IDLE;
            r_address     <= '0;
            r_n           <= '0;
            r_valid       <= 1'b0;
            r_err_bad_cmd <= 1'b0;
            r_err_timeout <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_address <= w_head[ADDR_W+3:4];
                        r_n       <= w_head[3:0];
                        r_valid   <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= (r_n == CLR_CACHE_RST) ? IDLE : WAIT;
                end
                WAIT: begin
                    if (opr_finished) begin
                        r_state <= IDLE;
                    end else if (r_wdog == WD_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept && !is_legal_cmd(cmd_n)) r_err_bad_cmd <= 1'b1;
        end
    end

    assign cmd_ready   = !w_full;
    assign address     = r_address;
    assign n           = r_n;
    assign valid       = r_valid;
    assign busy        = (r_state != IDLE) || !w_empty;
    assign err_bad_cmd = r_err_bad_cmd;
    assign err_timeout = r_err_timeout;

`ifdef CACHE_CMD_SEQ_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;
    logic [31:0] r_stat_snoop;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_snoop <= '0;
        end else if (r_state == ISSUE) begin
            case (r_n)
                READ_REQ_L1_D, READ_REQ_L1_I:
                    r_stat_rd <= r_stat_rd + 32'd1;
                WRITE_REQ_L1_D:
                    r_stat_wr <= r_stat_wr + 32'd1;
                SNOOP_INVALIDATE, SNOOP_READ, SNOOP_WRITE, SNOOP_READ_WITH_M:
                    r_stat_snoop <= r_stat_snoop + 32'd1;
                default: ;
            endcase
        end
    end

    assign stat_rd    = r_stat_rd;
    assign stat_wr    = r_stat_wr;
    assign stat_snoop = r_stat_snoop;
`else
    assign stat_rd    = '0;
    assign stat_wr    = '0;
    assign stat_snoop = '0;
`endif

endmodule
